mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_in  input  1  synchronous active-high reset.
REQ-004 start_mult  input  1  one-cycle request: signed multiply a*b.
REQ-005 start_div  input  1  one-cycle request: signed divide a/b.
REQ-006 a  input  32  operand A / dividend, two's complement.
REQ-007 b  input  32  operand B / divisor, two's complement.
REQ-008 hi  output  32  registered HI result (product[63:32] / remainder).
REQ-009 lo  output  32  registered LO result (product[31:0] / quotient).
REQ-010 mult_done  output  1  one-cycle pulse: multiply complete, hi/lo valid.
REQ-011 div_done  output  1  one-cycle pulse: divide complete, hi/lo valid or div-by-zero.
REQ-012 div_zero  output  1  one-cycle pulse with div_done when divisor was zero.
REQ-013 busy  output  1  high while an operation is in progress.

Function
REQ-014 The FSM SHALL have states IDLE, MULT, DIV, DONE, plus a 5-bit iteration counter.
REQ-015 In IDLE, the block SHALL sample start_mult/start_div at edge N, latch a and b, clear the counter and enter MULT or DIV.
REQ-016 If both starts are high in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-017 Starts arriving outside IDLE SHALL be ignored, with no effect on operands or results.
REQ-018 MULT and DIV SHALL run exactly 32 iterations, one per edge N+1..N+32; at edge N+33, hi/lo SHALL update, the done pulse SHALL assert, and state SHALL be DONE.
REQ-019 From DONE, the FSM SHALL return to IDLE at the next edge, dropping the done pulse; a new start is accepted there at the earliest.
REQ-020 busy SHALL be 1 in MULT and DIV, and 0 in IDLE and DONE.
REQ-021 Multiply: {hi,lo} SHALL equal the full 64-bit signed product; no overflow exists.
REQ-022 Divide: the quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend; lo = quotient, hi = remainder.
REQ-023 Divide 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 (wrap, no flag).
REQ-024 hi/lo SHALL hold their values between completions and SHALL change only at a completion edge or reset.

Reset
REQ-025 At a rising edge with reset_in=1: state=IDLE, counter=0, hi=0, lo=0, mult_done=0, div_done=0, div_zero=0, busy=0.
REQ-026 Reset SHALL take priority over start, and a reset mid-operation SHALL abort without a done pulse or hi/lo update.

Configuration
REQ-027 Macro MULT_DIV_DIVZERO_CHECK_EN SHALL control divide-by-zero detection.
REQ-028 With the macro defined, b==0 at start_div capture edge N SHALL cause DIV to be skipped: at edge N+1, div_done=1 and div_zero=1 for one cycle, and hi/lo SHALL be unchanged.
REQ-029 Without the macro, div_zero SHALL be tied 0 and a zero divisor SHALL run the full 32 iterations.
REQ-030 Without the macro and with b==0, the result SHALL be hi=a; lo=0xFFFFFFFF if a>=0, else lo=0x00000001.

Verification
REQ-031 Scenario: a=7, b=-3, start_mult -> at N+33, mult_done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 32 cycles.
REQ-032 Scenario: a=-7, b=2, start_div -> at N+33, div_done pulse, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 Scenario: a=0x80000000, b=0xFFFFFFFF, start_div -> lo=0x80000000, hi=0, div_zero=0.
REQ-034 Scenario: a=5, b=0, start_div -> with macro: div_done and div_zero at N+1, hi/lo unchanged; without macro: div_done at N+33, hi=5, lo=0xFFFFFFFF.
REQ-035 Scenario: start_mult and start_div in the same cycle (a=3, b=4) -> only mult_done, lo=12; a start_div pulsed at N+10 is ignored.
REQ-036 Scenario: reset_in pulsed at N+15 during multiply -> the next edge shows IDLE, hi=lo=0, and no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if -- request/result bundle for the multiply/divide unit.
//   start_mult, start_div : one-cycle operation requests
//   a, b                  : operands (two's complement)
//   hi, lo                : registered results
//   mult_done, div_done   : one-cycle completion pulses
//   div_zero              : divide-by-zero pulse (with div_done)
//   busy                  : operation in progress
// master = requester, slave = mult_div_unit.
interface mult_div_unit_if;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_done;
    logic        div_done;
    logic        div_zero;
    logic        busy;

    modport master (
        output start_mult, start_div, a, b,
        input  hi, lo, mult_done, div_done, div_zero, busy
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output hi, lo, mult_done, div_done, div_zero, busy
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32x32 signed multiply and signed divide.
// Ports:
//   clk      : system clock, rising edge
//   reset_in : synchronous active-high reset
//   bus      : mult_div_unit_if.slave (starts, operands, hi/lo, done pulses, busy)
// Operation: operands are captured as magnitudes, 32 shift-add (multiply) or
// restoring-subtract (divide) steps run one per clock, and the signs are
// applied on a final completion edge where hi/lo and the done pulse update.
// Optional feature: define MULT_DIV_DIVZERO_CHECK_EN to short-circuit a zero
// divisor (div_done + div_zero one edge after capture, hi/lo untouched).
// Without it div_zero is constant 0 and b==0 runs the normal divide.
//
// state | meaning
// IDLE  | waiting for start_mult / start_div
// MULT  | 32 shift-add steps, then completion edge
// DIV   | 32 restoring-divide steps, then completion edge
// DONE  | done pulse visible, back to IDLE next edge
module mult_div_unit (
    input  logic           clk,
    input  logic           reset_in,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opd_q, opd_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
`ifdef MULT_DIV_DIVZERO_CHECK_EN
    logic        zero_q, zero_d;
`endif
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        mult_done_q, mult_done_d;
    logic        div_done_q, div_done_d;
    logic        div_zero_q, div_zero_d;
    logic        busy_q, busy_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_rem_sh;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] prod_signed;

    always_comb begin
        mag_a = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
        mag_b = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);

        // Divide: acc = {remainder, dividend bits shifting into quotient}.
        // The remainder stays below the divisor, so the difference fits 32 bits.
        div_rem_sh = acc_q[63:31];
        div_ge     = div_rem_sh >= {1'b0, opd_q};
        div_sub    = div_rem_sh[31:0] - opd_q;

        prod_signed = neg_q ? (~acc_q + 64'd1) : acc_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        acc_d       = acc_q;
        opd_d       = opd_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
`ifdef MULT_DIV_DIVZERO_CHECK_EN
        zero_d      = zero_q;
`endif
        hi_d        = hi_q;
        lo_d        = lo_q;
        mult_done_d = 1'b0;
        div_done_d  = 1'b0;
        div_zero_d  = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                cnt_d  = 5'd0;
                last_d = 1'b0;
                neg_d  = bus.a[31] ^ bus.b[31];
                rneg_d = bus.a[31];
                if (bus.start_mult) begin
                    state_d = MULT;
                    acc_d   = {32'd0, mag_b};
                    opd_d   = mag_a;
                    busy_d  = 1'b1;
                end else if (bus.start_div) begin
                    state_d = DIV;
                    acc_d   = {32'd0, mag_a};
                    opd_d   = mag_b;
                    busy_d  = 1'b1;
`ifdef MULT_DIV_DIVZERO_CHECK_EN
                    zero_d  = (bus.b == 32'd0);
`endif
                end
            end
            MULT: begin
                if (last_q) begin
                    hi_d        = prod_signed[63:32];
                    lo_d        = prod_signed[31:0];
                    mult_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else begin
                    acc_d  = {mul_sum, acc_q[31:1]};
                    cnt_d  = cnt_q + 5'd1;
                    last_d = (cnt_q == 5'd31);
                end
            end
            DIV: begin
`ifdef MULT_DIV_DIVZERO_CHECK_EN
                if (zero_q) begin
                    div_done_d = 1'b1;
                    div_zero_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end else
`endif
                if (last_q) begin
                    lo_d       = neg_q  ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
                    hi_d       = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
                    div_done_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = DONE;
                end else begin
                    acc_d  = div_ge ? {div_sub, acc_q[30:0], 1'b1}
                                    : {div_rem_sh[31:0], acc_q[30:0], 1'b0};
                    cnt_d  = cnt_q + 5'd1;
                    last_d = (cnt_q == 5'd31);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            last_q      <= 1'b0;
            acc_q       <= 64'd0;
            opd_q       <= 32'd0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
`ifdef MULT_DIV_DIVZERO_CHECK_EN
            zero_q      <= 1'b0;
`endif
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            mult_done_q <= 1'b0;
            div_done_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            opd_q       <= opd_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
`ifdef MULT_DIV_DIVZERO_CHECK_EN
            zero_q      <= zero_d;
`endif
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mult_done_q <= mult_done_d;
            div_done_q  <= div_done_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.mult_done = mult_done_q;
    assign bus.div_done  = div_done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
    logic clk;
    logic reset_in;
    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_mult;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          zero;
        int          due;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever a done pulse appears.
    always @(negedge clk) begin
        if (!reset_in && (bus.mult_done || bus.div_done)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: got mult_done=%b div_done=%b at cycle %0d expected no pulse",
                         bus.mult_done, bus.div_done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mult_done", {31'd0, bus.mult_done}, {31'd0, e.is_mult});
                check("div_done",  {31'd0, bus.div_done},  {31'd0, !e.is_mult});
                check("hi",        bus.hi, e.hi);
                check("lo",        bus.lo, e.lo);
                check("div_zero",  {31'd0, bus.div_zero},  {31'd0, e.zero});
                check("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic issue(input bit m, input bit d, input logic [31:0] ia, input logic [31:0] ib,
                         output int n);
        @(negedge clk);
        bus.start_mult = m;
        bus.start_div  = d;
        bus.a          = ia;
        bus.b          = ib;
        @(posedge clk);
        #1;
        n = cyc;
        @(negedge clk);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
    endtask

    task automatic push(input bit m, input logic [31:0] h, input logic [31:0] l,
                        input bit z, input int due);
        exp_t e;
        e.is_mult = m;
        e.hi      = h;
        e.lo      = l;
        e.zero    = z;
        e.due     = due;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) break;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input bit m, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] h, input logic [31:0] l);
        int n;
        issue(m, !m, ia, ib, n);
        push(m, h, l, 1'b0, n + 33);
        wait_idle();
    endtask

    initial begin
        int n;
        reset_in       = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi",   bus.hi, 32'd0);
        check("rst_lo",   bus.lo, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {30'd0, bus.mult_done, bus.div_done}, 32'd0);
        check("rst_zero", {31'd0, bus.div_zero}, 32'd0);
        reset_in = 1'b0;

        // 7 * -3 = -21 with busy profile checks
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, n);
        push(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, n + 33);
        check("busy_first", {31'd0, bus.busy}, 32'd1);
        repeat (31) @(negedge clk);
        check("busy_last", {31'd0, bus.busy}, 32'd1);
        wait_idle();
        check("busy_after", {31'd0, bus.busy}, 32'd0);

        run_op(1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD); // -7/2
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000); // wrap

        // Zero divisor
`ifdef MULT_DIV_DIVZERO_CHECK_EN
        issue(1'b0, 1'b1, 32'd5, 32'd0, n);
        push(1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, n + 1);
        wait_idle();
        issue(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, n);
        push(1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, n + 1);
        wait_idle();
`else
        run_op(1'b0, 32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF);
        run_op(1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001);
`endif

        run_op(1'b1, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0000_0001, 32'h0000_0000);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001);
        run_op(1'b0, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op(1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);
        run_op(1'b0, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2);

        // Both starts together: multiply wins; a later start_div is ignored
        issue(1'b1, 1'b1, 32'd3, 32'd4, n);
        push(1'b1, 32'd0, 32'd12, 1'b0, n + 33);
        repeat (9) @(negedge clk);
        bus.start_div = 1'b1;
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        @(negedge clk);
        bus.start_div = 1'b0;
        wait_idle();

        // Reset at N+15 aborts the multiply with no done pulse
        issue(1'b1, 1'b0, 32'd9, 32'd9, n);
        repeat (14) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_hi",   bus.hi, 32'd0);
        check("abort_lo",   bus.lo, 32'd0);
        check("abort_done", {30'd0, bus.mult_done, bus.div_done}, 32'd0);
        repeat (40) @(negedge clk);

        run_op(1'b1, 32'd6, 32'd7, 32'd0, 32'd42);

        // hi/lo hold while idle
        repeat (10) @(negedge clk);
        check("hold_hi", bus.hi, 32'd0);
        check("hold_lo", bus.lo, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end
endmodule
